// File: rtl/lsu_ctrl_pkg.sv
// Shared load/store types: AGU op encoding, LSU control bundles, FSM states
// and access-fault cause codes.
package lsu_ctrl_pkg;

  typedef struct packed {
    logic lb, lbu, lh, lhu, lw, sb, sh, sw;
  } lsu_op_type;

  typedef struct packed {
    logic        store;
    lsu_op_type  op;
    logic [31:0] address;
    logic [3:0]  byteenable;
    logic [31:0] wdata;
  } lsu_ctrl_in_type;

  typedef struct packed {
    logic        result_valid;
    logic [31:0] result;
    logic        exception;
    logic [3:0]  ecause;
    logic [31:0] etval;
  } lsu_ctrl_out_type;

  typedef enum logic [1:0] {LSU_IDLE, LSU_BUSY, LSU_DONE} lsu_state_type;

  localparam logic [3:0] except_load_access_fault  = 4'd5;
  localparam logic [3:0] except_store_access_fault = 4'd7;

endpackage

// File: rtl/lsu_ctrl_align.sv
// Store-data lane replication and load-data extraction/extension.
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  lsu_op_type  op,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] store_data,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    shifted    = rdata >> {offset, 3'b000};
    store_data = '0;
    load_data  = '0;

    if (op.sb)      store_data = {4{wdata[7:0]}};
    else if (op.sh) store_data = {2{wdata[15:0]}};
    else if (op.sw) store_data = wdata;

    if (op.lb)       load_data = {{24{shifted[7]}}, shifted[7:0]};
    else if (op.lbu) load_data = {24'b0, shifted[7:0]};
    else if (op.lh)  load_data = {{16{shifted[15]}}, shifted[15:0]};
    else if (op.lhu) load_data = {16'b0, shifted[15:0]};
    else if (op.lw)  load_data = shifted;
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control: accepts one AGU request, runs a single valid/ready
// data-memory transaction, stalls the pipeline and returns data or a fault.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 0
)
(
  input  logic        reset,
  input  logic        clock,
  input  logic        req_valid,
  input  logic        req_store,
  input  lsu_op_type  lsu_op,
  input  logic [31:0] address,
  input  logic [3:0]  byteenable,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        dmem_valid,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic        dmem_error,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] result,
  output logic        exception,
  output logic [3:0]  ecause,
  output logic [31:0] etval
);

  lsu_state_type    state, state_next;
  lsu_ctrl_in_type  req_q;
  lsu_ctrl_out_type out;
  logic [31:0]      count_q, rdata_q;
  logic             error_q, killed_q;
  logic             accept, expire;
  logic [31:0]      store_data, load_data;

  lsu_align u_align (
    .op         (req_q.op),
    .offset     (req_q.address[1:0]),
    .wdata      (req_q.wdata),
    .rdata      (rdata_q),
    .store_data (store_data),
    .load_data  (load_data)
  );

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    expire     = 1'b0;
    case (state)
      LSU_IDLE: begin
        if (req_valid && !flush) begin
          accept     = 1'b1;
          state_next = LSU_BUSY;
        end
      end
      LSU_BUSY: begin
        // ready takes priority over a coinciding timeout expiry
        if (dmem_ready) begin
          state_next = LSU_DONE;
        end else if (TIMEOUT != 0 && count_q == TIMEOUT - 1) begin
          expire     = 1'b1;
          state_next = LSU_DONE;
        end
      end
      LSU_DONE: state_next = LSU_IDLE;
      default:  state_next = LSU_IDLE;
    endcase
  end

  always_comb begin
    stall      = accept || (state == LSU_BUSY);
    dmem_valid = (state == LSU_BUSY);
    dmem_addr  = dmem_valid ? {req_q.address[31:2], 2'b00} : '0;
    dmem_wstrb = (dmem_valid && req_q.store) ? req_q.byteenable : '0;
    dmem_wdata = dmem_valid ? store_data : '0;

    out = '0;
    // a flush seen during BUSY or in DONE itself kills the completion
    if (state == LSU_DONE && !killed_q && !flush) begin
      out.result_valid = 1'b1;
      out.exception    = error_q;
      if (error_q) begin
        out.ecause = req_q.store ? except_store_access_fault : except_load_access_fault;
        out.etval  = req_q.address;
      end else if (!req_q.store) begin
        out.result = load_data;
      end
    end

    result_valid = out.result_valid;
    result       = out.result;
    exception    = out.exception;
    ecause       = out.ecause;
    etval        = out.etval;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= LSU_IDLE;
      req_q    <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
      killed_q <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        req_q    <= '{store: req_store, op: lsu_op, address: address,
                      byteenable: byteenable, wdata: wdata};
        count_q  <= '0;
        error_q  <= 1'b0;
        killed_q <= 1'b0;
      end
      if (state == LSU_BUSY) begin
        if (flush) killed_q <= 1'b1;
        if (dmem_ready) begin
          rdata_q <= dmem_rdata;
          error_q <= dmem_error;
        end else if (expire) begin
          error_q <= 1'b1;
        end else begin
          count_q <= count_q + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: transaction-level reference model with a
// per-cycle compare process, directed corner cases and randomized traffic.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  localparam int unsigned TO = 8;
  localparam int LB = 0, LBU = 1, LH = 2, LHU = 3, LW = 4, SB = 5, SH = 6, SW = 7;

  logic        reset, clock;
  logic        req_valid, req_store, flush;
  lsu_op_type  lsu_op;
  logic [31:0] address, wdata;
  logic [3:0]  byteenable;
  logic        dmem_valid, dmem_ready, dmem_error;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        stall, result_valid, exception;
  logic [31:0] result, etval;
  logic [3:0]  ecause;

  lsu_ctrl #(.TIMEOUT(TO)) dut (
    .reset(reset), .clock(clock), .req_valid(req_valid), .req_store(req_store),
    .lsu_op(lsu_op), .address(address), .byteenable(byteenable), .wdata(wdata),
    .flush(flush), .dmem_valid(dmem_valid), .dmem_addr(dmem_addr),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_error(dmem_error), .dmem_rdata(dmem_rdata), .stall(stall),
    .result_valid(result_valid), .result(result), .exception(exception),
    .ecause(ecause), .etval(etval)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0, errors = 0;
  logic        chk_en = 1'b0;
  logic        e_stall, e_dvalid, e_chk_wdata, e_rvalid, e_exc;
  logic [31:0] e_addr, e_wdata, e_result, e_etval;
  logic [3:0]  e_wstrb, e_ecause;
  logic [31:0] last_result, last_etval, last_wdata;
  logic [3:0]  last_ecause, last_wstrb;
  logic        last_exc;
  int          busy_cnt, rv_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outputs derived from the op semantics with plain arithmetic.
  function automatic lsu_op_type to_op(input int code);
    lsu_op_type o;
    o = '0;
    case (code)
      LB: o.lb = 1'b1;  LBU: o.lbu = 1'b1; LH: o.lh = 1'b1; LHU: o.lhu = 1'b1;
      LW: o.lw = 1'b1;  SB: o.sb = 1'b1;   SH: o.sh = 1'b1; default: o.sw = 1'b1;
    endcase
    return o;
  endfunction

  function automatic int op_size(input int code);
    if (code == LB || code == LBU || code == SB) return 1;
    if (code == LH || code == LHU || code == SH) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_be(input int code, input logic [1:0] off);
    int unsigned mask;
    mask = (1 << op_size(code)) - 1;
    return 4'(mask << off);
  endfunction

  function automatic logic [31:0] m_store(input int code, input logic [31:0] w);
    logic [31:0] b, h;
    b = w & 32'hFF;
    h = w & 32'hFFFF;
    if (op_size(code) == 1) return b * 32'h0101_0101;
    if (op_size(code) == 2) return h * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input int code, input logic [1:0] off, input logic [31:0] rd);
    logic [31:0] v;
    logic signed [31:0] s;
    v = rd >> (8 * int'(off));
    case (code)
      LB:  begin s = $signed(v[7:0]);  return s; end
      LBU: return v % 256;
      LH:  begin s = $signed(v[15:0]); return s; end
      LHU: return v % 65536;
      default: return v;
    endcase
  endfunction

  always @(negedge clock) begin
    if (dmem_valid) begin busy_cnt++; last_wdata = dmem_wdata; last_wstrb = dmem_wstrb; end
    if (result_valid) begin
      rv_cnt++;
      last_result = result; last_exc = exception; last_ecause = ecause; last_etval = etval;
    end
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(e_stall));
      chk("dmem_valid", 32'(dmem_valid), 32'(e_dvalid));
      if (e_dvalid) begin
        chk("dmem_addr", dmem_addr, e_addr);
        chk("dmem_wstrb", 32'(dmem_wstrb), 32'(e_wstrb));
        if (e_chk_wdata) chk("dmem_wdata", dmem_wdata, e_wdata);
      end
      chk("result_valid", 32'(result_valid), 32'(e_rvalid));
      chk("exception", 32'(exception), 32'(e_exc));
      if (e_rvalid) chk("result", result, e_result);
      if (e_exc) begin
        chk("ecause", 32'(ecause), 32'(e_ecause));
        chk("etval", etval, e_etval);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic exp_idle();
    e_stall = 1'b0; e_dvalid = 1'b0; e_rvalid = 1'b0; e_exc = 1'b0; e_chk_wdata = 1'b0;
  endtask

  task automatic clr_last();
    last_result = 'x; last_exc = 1'bx; last_ecause = 'x; last_etval = 'x;
    last_wdata = 'x; last_wstrb = 'x; busy_cnt = 0; rv_cnt = 0;
  endtask

  // One full transaction starting in IDLE; waitc >= TO means ready never comes.
  task automatic txn(input int code, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] rd, input int waitc, input logic err,
                     input int flush_at, input logic flush_done);
    logic st, killed, fin_err;
    logic [3:0] be;
    int last_b;
    st = (code >= SB);
    be = m_be(code, addr[1:0]);
    if (waitc <= int'(TO) - 1) begin last_b = waitc; fin_err = err; end
    else begin last_b = int'(TO) - 1; fin_err = 1'b1; end

    req_valid = 1'b1; req_store = st; lsu_op = to_op(code); address = addr;
    byteenable = be; wdata = wd; flush = 1'b0; dmem_ready = 1'b0;
    exp_idle(); e_stall = 1'b1;
    step();

    killed = 1'b0;
    for (int b = 0; b <= last_b; b++) begin
      req_valid = 1'($urandom_range(0, 1)); address = $urandom(); wdata = $urandom();
      flush = (b == flush_at);
      if (flush) killed = 1'b1;
      dmem_ready = (b == waitc);
      dmem_error = (b == waitc) ? err : 1'($urandom_range(0, 1));
      dmem_rdata = (b == waitc) ? rd : $urandom();
      exp_idle();
      e_stall = 1'b1; e_dvalid = 1'b1; e_addr = {addr[31:2], 2'b00};
      e_wstrb = st ? be : 4'h0; e_chk_wdata = st; e_wdata = m_store(code, wd);
      step();
    end

    dmem_ready = 1'b0; dmem_error = 1'b0; flush = flush_done;
    req_valid = 1'($urandom_range(0, 1));
    exp_idle();
    e_rvalid = !(killed || flush_done);
    e_exc    = e_rvalid && fin_err;
    e_result = (st || fin_err) ? 32'h0 : m_load(code, addr[1:0], rd);
    e_ecause = st ? 4'd7 : 4'd5;
    e_etval  = addr;
    step();
    req_valid = 1'b0; flush = 1'b0;
    exp_idle();
  endtask

  logic [31:0] ra, rw, rr;
  int          rc, rwait, rfl;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; lsu_op = '0; address = '0;
    byteenable = '0; wdata = '0; flush = 1'b0; dmem_ready = 1'b0; dmem_error = 1'b0;
    dmem_rdata = '0;
    exp_idle();
    step(); step();
    chk("reset_stall", 32'(stall), 32'h0);
    chk("reset_dmem_valid", 32'(dmem_valid), 32'h0);
    chk("reset_result_valid", 32'(result_valid), 32'h0);
    chk("reset_exception", 32'(exception), 32'h0);
    reset = 1'b0;
    chk_en = 1'b1;
    step();

    clr_last();
    txn(LW, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, -1, 1'b0);
    chk("lw_result", last_result, 32'hDEAD_BEEF);
    chk("lw_busy_cycles", 32'(busy_cnt), 32'd1);

    clr_last(); txn(LB, 32'h103, 32'h0, 32'h8000_0000, 1, 1'b0, -1, 1'b0);
    chk("lb_result", last_result, 32'hFFFF_FF80);
    clr_last(); txn(LBU, 32'h103, 32'h0, 32'h8000_0000, 0, 1'b0, -1, 1'b0);
    chk("lbu_result", last_result, 32'h0000_0080);
    clr_last(); txn(LH, 32'h102, 32'h0, 32'h8000_0000, 2, 1'b0, -1, 1'b0);
    chk("lh_result", last_result, 32'hFFFF_8000);

    clr_last(); txn(SH, 32'h206, 32'h1234_ABCD, 32'h0, 3, 1'b0, -1, 1'b0);
    chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
    chk("sh_wstrb", 32'(last_wstrb), 32'hC);
    chk("sh_busy_cycles", 32'(busy_cnt), 32'd4);
    chk("sh_result", last_result, 32'h0);

    clr_last(); txn(SW, 32'h204, 32'h5555_AAAA, 32'h0, 1, 1'b1, -1, 1'b0);
    chk("sw_err_exc", 32'(last_exc), 32'h1);
    chk("sw_err_ecause", 32'(last_ecause), 32'd7);
    chk("sw_err_etval", last_etval, 32'h204);
    clr_last(); txn(LW, 32'h204, 32'h0, 32'h1111_2222, 1, 1'b1, -1, 1'b0);
    chk("lw_err_ecause", 32'(last_ecause), 32'd5);
    chk("lw_err_result", last_result, 32'h0);

    clr_last(); txn(LW, 32'h300, 32'h0, 32'h7777_7777, 1000, 1'b0, -1, 1'b0);
    chk("timeout_busy_cycles", 32'(busy_cnt), 32'd8);
    chk("timeout_exc", 32'(last_exc), 32'h1);
    clr_last(); txn(LW, 32'h300, 32'h0, 32'h7777_7777, 7, 1'b0, -1, 1'b0);
    chk("ready_at_expiry_exc", 32'(last_exc), 32'h0);
    chk("ready_at_expiry_result", last_result, 32'h7777_7777);

    clr_last(); txn(LW, 32'h400, 32'h0, 32'h1234_5678, 2, 1'b1, 1, 1'b0);
    chk("flush_busy_rv_count", 32'(rv_cnt), 32'd0);

    clr_last();
    req_valid = 1'b1; flush = 1'b1; lsu_op = to_op(LW); address = 32'h500; byteenable = 4'hF;
    exp_idle();
    for (int i = 0; i < 3; i++) step();
    req_valid = 1'b0; flush = 1'b0;
    step();
    chk("idle_flush_dmem_valid_count", 32'(busy_cnt), 32'd0);

    // reset while BUSY: request held for this cycle, gone the next
    req_valid = 1'b1; req_store = 1'b0; lsu_op = to_op(LW); address = 32'h600; byteenable = 4'hF;
    exp_idle(); e_stall = 1'b1;
    step();
    req_valid = 1'b0;
    exp_idle(); e_stall = 1'b1; e_dvalid = 1'b1; e_addr = 32'h600; e_wstrb = 4'h0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_idle();
    step();
    clr_last(); txn(LHU, 32'h602, 32'h0, 32'hBEEF_0000, 0, 1'b0, -1, 1'b0);
    chk("after_reset_lhu", last_result, 32'h0000_BEEF);

    for (int n = 0; n < 250; n++) begin
      rc = $urandom_range(0, 7);
      ra = $urandom();
      if (op_size(rc) == 2) ra[0] = 1'b0;
      if (op_size(rc) == 4) ra[1:0] = 2'b00;
      rw = $urandom(); rr = $urandom();
      rwait = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 10) : $urandom_range(0, 4);
      rfl = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4) : -1;
      txn(rc, ra, rw, rr, rwait, 1'($urandom_range(0, 7) == 0), rfl,
          1'($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 2) == 0) step();
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
